// File: rtl/pooling_window_feeder.sv
// pooling_window_feeder
// Packs a serial float32 pixel stream into KERNEL_SIZE-wide window words.
// The words are queued in a small FIFO and issued to the max-pooling kernel
// as single-cycle pulses, spaced ISSUE_GAP cycles apart.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   in_data/valid    float32 pixel stream, row-major, feature-interleaved per row
//   in_ready         high while the window FIFO is not full
//   out_data         packed window; first (leftmost) column in the MSBs
//   out_feature_idx  feature map of the issued window
//   out_feature_row  row of the issued window
//   out_valid        one-cycle issue pulse (kernel input_valid)
//   frame_done       pulses together with the last window of a frame
//
// Optional build macro POOL_FEEDER_STATS_EN adds two saturating counters:
//   issued_cnt       number of out_valid pulses
//   stall_cnt        cycles with in_valid=1 and in_ready=0
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_window_feeder #(
  parameter int INPUT_SIZE    = 6,
  parameter int KERNEL_SIZE   = 2,
  parameter int TOTAL_FEATURE = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int ISSUE_GAP     = 3,
  localparam int DW = `DATA_WIDTH,
  localparam int FW = (TOTAL_FEATURE > 1) ? $clog2(TOTAL_FEATURE) : 1,
  localparam int RW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DW-1:0]             in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [KERNEL_SIZE*DW-1:0] out_data,
  output logic [FW-1:0]             out_feature_idx,
  output logic [RW-1:0]             out_feature_row,
  output logic                      out_valid,
  output logic                      frame_done
`ifdef POOL_FEEDER_STATS_EN
  ,
  output logic [15:0]               issued_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int CW = RW;
  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(ISSUE_GAP) + 1;
  localparam int WW = KERNEL_SIZE * DW;
  localparam int EW = WW + FW + RW + 1;

  typedef enum logic {S_IDLE, S_GAP} state_t;

  // Position counters of the next pixel to be accepted
  logic [CW-1:0] r_col;
  logic [FW-1:0] r_feat;
  logic [RW-1:0] r_row;
  logic [KW-1:0] r_kidx;

  // FIFO storage and bookkeeping
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  // Issue FSM and registered outputs
  state_t        r_state;
  logic [GW-1:0] r_gap;
  logic          r_issue;
  logic          r_head_last;
  logic [WW-1:0] r_out_data;
  logic [FW-1:0] r_out_feat;
  logic [RW-1:0] r_out_row;
  logic          r_out_valid;
  logic          r_frame_done;

  logic          w_accept, w_push, w_pop, w_last;
  logic          w_col_last, w_feat_last, w_row_last, w_k_last;
  logic [WW-1:0] w_word;
  logic [EW-1:0] w_head;

  assign in_ready    = (r_count != (AW+1)'(FIFO_DEPTH));
  assign w_accept    = in_valid && in_ready;
  assign w_col_last  = (r_col  == CW'(INPUT_SIZE - 1));
  assign w_feat_last = (r_feat == FW'(TOTAL_FEATURE - 1));
  assign w_row_last  = (r_row  == RW'(INPUT_SIZE - 1));
  assign w_k_last    = (r_kidx == KW'(KERNEL_SIZE - 1));
  assign w_last      = w_row_last && w_feat_last && w_col_last;
  assign w_push      = w_accept && w_k_last;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];

  // Earlier pixels of the current window shift towards the MSBs; the
  // closing pixel is concatenated directly so the word is complete on its
  // own accepting edge.
  generate
    if (KERNEL_SIZE > 1) begin : g_shift
      logic [(KERNEL_SIZE-1)*DW-1:0] r_shift;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shift <= '0;
        end else if (w_accept) begin
          if (KERNEL_SIZE > 2)
            r_shift <= {r_shift[(KERNEL_SIZE-1)*DW-1-((KERNEL_SIZE>2)?DW:0):0], in_data};
          else
            r_shift <= in_data;
        end
      end
      assign w_word = {r_shift, in_data};
    end else begin : g_noshift
      assign w_word = in_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_feat <= '0;
      r_row  <= '0;
      r_kidx <= '0;
    end else if (w_accept) begin
      r_kidx <= w_k_last ? '0 : r_kidx + 1'b1;
      if (w_col_last) begin
        r_col <= '0;
        if (w_feat_last) begin
          r_feat <= '0;
          r_row  <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_feat <= r_feat + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Storage is not reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {w_word, r_feat, r_row, w_last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Pop loads the window registers; out_valid follows one cycle later so the
  // pulse is fully registered. The gap counter holds the FSM off the FIFO
  // for ISSUE_GAP-1 cycles after every pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gap        <= '0;
      r_issue      <= 1'b0;
      r_head_last  <= 1'b0;
      r_out_data   <= '0;
      r_out_feat   <= '0;
      r_out_row    <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_issue      <= 1'b0;
      r_out_valid  <= r_issue;
      r_frame_done <= r_issue && r_head_last;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_out_data  <= w_head[EW-1 -: WW];
            r_out_feat  <= w_head[RW+1 +: FW];
            r_out_row   <= w_head[1 +: RW];
            r_head_last <= w_head[0];
            r_issue     <= 1'b1;
            r_gap       <= GW'(ISSUE_GAP - 1);
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap <= GW'(1))
            r_state <= S_IDLE;
          else
            r_gap <= r_gap - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data        = r_out_data;
  assign out_feature_idx = r_out_feat;
  assign out_feature_row = r_out_row;
  assign out_valid       = r_out_valid;
  assign frame_done      = r_frame_done;

`ifdef POOL_FEEDER_STATS_EN
  logic [15:0] r_issued_cnt, r_stall_cnt;

  // issued_cnt steps on the same edge that raises out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (r_issue && r_issued_cnt != 16'hFFFF)
        r_issued_cnt <= r_issued_cnt + 1'b1;
      if (in_valid && !in_ready && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign issued_cnt = r_issued_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pooling_window_feeder.sv
module tb_pooling_window_feeder;

  localparam int IS = 6;
  localparam int KS = 2;
  localparam int TF = 4;
  localparam int FD = 4;
  localparam int IG = 3;
  localparam int FRAME_PIX = IS * IS * TF;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [1:0]  out_feature_idx;
  logic [2:0]  out_feature_row;
  logic        out_valid;
  logic        frame_done;
`ifdef POOL_FEEDER_STATS_EN
  logic [15:0] issued_cnt;
  logic [15:0] stall_cnt;
`endif

  pooling_window_feeder #(
    .INPUT_SIZE(IS), .KERNEL_SIZE(KS), .TOTAL_FEATURE(TF),
    .FIFO_DEPTH(FD), .ISSUE_GAP(IG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_feature_idx(out_feature_idx),
    .out_feature_row(out_feature_row),
    .out_valid(out_valid),
    .frame_done(frame_done)
`ifdef POOL_FEEDER_STATS_EN
    ,
    .issued_cnt(issued_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    int          feat;
    int          row;
    bit          last;
  } win_t;

  // Reference model: a window is expected for every odd column, tagged by
  // the pixel's position inside the frame.
  win_t        exp_q[$];
  int          pulse_q[$];
  int          mpos = 0;
  logic [31:0] mprev = '0;
  int          stall_seen = 0;
  int          issued_seen = 0;
  int          fd_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [31:0] d);
    int col, feat, row;
    win_t w;
    col  = mpos % IS;
    feat = (mpos / IS) % TF;
    row  = mpos / (IS * TF);
    if (col % KS == KS - 1) begin
      w.data = {mprev, d};
      w.feat = feat;
      w.row  = row;
      w.last = (mpos == FRAME_PIX - 1);
      exp_q.push_back(w);
    end
    mprev = d;
    mpos  = (mpos + 1) % FRAME_PIX;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && !in_ready) stall_seen++;
      if (frame_done) begin
        fd_seen++;
        chk("fd_needs_valid", out_valid, 1);
      end
      if (out_valid) begin
        win_t w;
        pulse_q.push_back(cyc);
        issued_seen++;
        chk("pulse_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("win_data", out_data, w.data);
          chk("win_feat", out_feature_idx, w.feat);
          chk("win_row", out_feature_row, w.row);
          chk("win_frame_done", frame_done, w.last);
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", {out_feature_idx, out_feature_row}, 0);
    exp_q.delete();
    mpos        = 0;
    stall_seen  = 0;
    issued_seen = 0;
    fd_seen     = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
  endtask

  task automatic send(input logic [31:0] d, output int acc_edge);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    acc_edge = -1;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      acc_edge = cyc + 1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", acc, 1);
    if (acc) model_accept(d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (IG + 3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_stats();
`ifdef POOL_FEEDER_STATS_EN
    chk("issued_cnt", issued_cnt, issued_seen);
    chk("stall_cnt", stall_cnt, stall_seen);
`endif
  endtask

  initial begin
    int a, p0, r;
    logic [31:0] d0, d1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    do_reset();

    // Single window and issue latency
    send(32'h3F800000, a);
    send(32'h40000000, a);
    p0 = pulse_q.size();
    drain();
    chk("single_pulse_cnt", pulse_q.size() - p0, 1);
    chk("single_latency", pulse_q[p0], a + 2);
    chk("single_data_held", out_data, 64'h3F800000_40000000);
    chk("single_tag", {out_feature_idx, out_feature_row}, 0);
    check_stats();

    // Full frame streamed without gaps: FIFO fills and backpressure appears
    do_reset();
    p0 = pulse_q.size();
    for (int i = 0; i < FRAME_PIX; i++) send($urandom, a);
    drain();
    chk("frame_pulses", pulse_q.size() - p0, FRAME_PIX / KS);
    chk("frame_done_cnt", fd_seen, 1);
    chk("stall_seen", stall_seen > 0, 1);
    for (int i = p0 + 1; i < p0 + FRAME_PIX / KS && i < pulse_q.size(); i++)
      chk("issue_gap", pulse_q[i] - pulse_q[i-1], IG);
    check_stats();

    // First window of the next frame is tagged f0, r0
    send($urandom, a);
    send($urandom, a);
    drain();
    chk("wrap_tag", {out_feature_idx, out_feature_row}, 0);
    check_stats();

    // Mid-frame reset after 7 pixels
    do_reset();
    for (int i = 0; i < 7; i++) send($urandom, a);
    in_valid = 1'b0;
    do_reset();
    d0 = $urandom;
    d1 = $urandom;
    send(d0, a);
    send(d1, a);
    p0 = pulse_q.size();
    drain();
    chk("mid_rst_latency", pulse_q[p0], a + 2);
    chk("mid_rst_data", out_data, {d0, d1});
    chk("mid_rst_tag", {out_feature_idx, out_feature_row}, 0);
    check_stats();

    // Three back-to-back pairs: the third push lands on the pop of the second
    do_reset();
    p0 = pulse_q.size();
    for (int i = 0; i < 6; i++) send($urandom, a);
    drain();
    chk("pushpop_pulses", pulse_q.size() - p0, 3);
    chk("pushpop_issued", issued_seen, 3);
    if (pulse_q.size() >= p0 + 3) begin
      chk("pushpop_gap1", pulse_q[p0+1] - pulse_q[p0], IG);
      chk("pushpop_gap2", pulse_q[p0+2] - pulse_q[p0+1], IG);
    end
    check_stats();

    // Random input gaps
    for (int i = 0; i < 48; i++) begin
      send($urandom, a);
      r = $urandom_range(0, 3);
      if (r > 0) begin
        in_valid = 1'b0;
        repeat (r) @(posedge clk);
        #1;
      end
    end
    drain();
    check_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
